rr_mux_arbiter: RTL and testbench

//  Parametrised CHANNELS:1 data selector for streams with valid/ready handshakes.
//  - Replaces the fixed-select mux tree wherever several producers share one consumer.
//  - Picks an input by round-robin arbitration, or by an external select in forced mode.
//  - Holds the picked word in a one-entry output register, so out_data is glitch-free
//    and stable under backpressure.

---
 rtl/rr_mux_pkg.sv | 15 +
 rtl/rr_mux_arbiter_picker.sv | 38 +++
 rtl/rr_mux_arbiter.sv | 139 +++++++++++++
 tb/tb_rr_mux_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Package shared by the rr_mux_arbiter slice.
//   XFER_CNT_W / XFER_CNT_MAX : width and saturation value of the optional
//                               transfer counter (RR_MUX_STATS_EN builds).
//   mux_mode_t                : arbitration mode decoded from force_en.
package rr_mux_pkg;

  localparam int unsigned XFER_CNT_W = 16;
  localparam logic [XFER_CNT_W-1:0] XFER_CNT_MAX = '1;

  typedef enum logic {
    MODE_RR     = 1'b0,
    MODE_FORCED = 1'b1
  } mux_mode_t;

endpackage

// File: rtl/rr_mux_arbiter_picker.sv
// rr_picker: combinational round-robin picker.
// Returns the first requesting index found when scanning start_i,
// start_i+1, ... modulo CHANNELS.
//   req_i         in   CHANNELS  request vector
//   start_i       in   SEL_W     index that has highest priority
//   grant_o       out  SEL_W     granted index (0 when nothing granted)
//   grant_valid_o out  1         some request was found
module rr_picker
  import rr_mux_pkg::*;
#(
  parameter int CHANNELS = 8,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_W-1:0]    start_i,
  output logic [SEL_W-1:0]    grant_o,
  output logic                grant_valid_o
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = start_i;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (!found && req_i[idx]) begin
        grant_o = idx;
        found   = 1'b1;
      end
      // Explicit wrap: CHANNELS need not be a power of two.
      idx = (idx == SEL_W'(CHANNELS - 1)) ? '0 : idx + 1'b1;
    end
    grant_valid_o = found;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: CHANNELS:1 valid/ready stream selector with a one-entry
// registered output. Round-robin arbitration, or an external select when
// force_en is high.
//   clk, rst_n    clock, asynchronous active-low reset
//   in_data       CHANNELS*N, channel i at [i*N +: N]
//   in_valid      per-channel valid
//   in_ready      per-channel ready, one-hot or zero
//   force_en      1 = forced mode (use force_sel), 0 = round-robin
//   force_sel     forced channel index (>= CHANNELS never grants)
//   out_data      registered output word
//   out_channel   channel that supplied out_data
//   out_valid     output register holds a word
//   out_ready     consumer accepts the word this cycle
//   xfer_count    saturating input-side transfer count, only when
//                 RR_MUX_STATS_EN is defined
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N        = 1,
  parameter int CHANNELS = 8,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready,
  input  logic                  force_en,
  input  logic [SEL_W-1:0]      force_sel,
  output logic [N-1:0]          out_data,
  output logic [SEL_W-1:0]      out_channel,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef RR_MUX_STATS_EN
  ,
  output logic [XFER_CNT_W-1:0] xfer_count
`endif
);

  mux_mode_t        mode;
  logic             load;
  logic             xfer;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_grant_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic [N-1:0]     sel_data;

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_channel_q, out_channel_d;

  rr_picker #(.CHANNELS(CHANNELS)) u_picker (
    .req_i         (in_valid),
    .start_i       (rr_ptr_q),
    .grant_o       (rr_grant),
    .grant_valid_o (rr_grant_valid)
  );

  always_comb begin
    mode        = force_en ? MODE_FORCED : MODE_RR;
    load        = !out_valid_q || out_ready;
    grant       = rr_grant;
    grant_valid = rr_grant_valid;

    unique case (mode)
      MODE_FORCED: begin
        // Out-of-range force_sel matches no channel, so no grant.
        grant       = force_sel;
        grant_valid = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (force_sel == SEL_W'(i) && in_valid[i]) grant_valid = 1'b1;
        end
      end
      default: ;
    endcase

    in_ready = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) sel_data = in_data[i*N +: N];
      in_ready[i] = load && grant_valid && (grant == SEL_W'(i));
    end

    xfer          = load && grant_valid;
    rr_ptr_d      = rr_ptr_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;

    if (load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d    = sel_data;
        out_channel_d = grant;
        rr_ptr_d      = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;

`ifdef RR_MUX_STATS_EN
  logic [XFER_CNT_W-1:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (xfer && xfer_count_q != XFER_CNT_MAX) xfer_count_d = xfer_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_count_q <= '0;
    else        xfer_count_q <= xfer_count_d;
  end

  assign xfer_count = xfer_count_q;
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with N=8, CHANNELS=5.
// Channel i carries 8'hD0+i unless a vector overrides the data word.
module tb_rr_mux_arbiter;

  localparam int N  = 8;
  localparam int CH = 5;
  localparam int SW = 3;

  localparam logic [CH*N-1:0] DB = 40'hD4D3D2D1D0;
  localparam logic [CH*N-1:0] DA = 40'hD4D3A5D1D0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [CH*N-1:0] in_data = '0;
  logic [CH-1:0]   in_valid = '0;
  logic [CH-1:0]   in_ready;
  logic            force_en = 1'b0;
  logic [SW-1:0]   force_sel = '0;
  logic [N-1:0]    out_data;
  logic [SW-1:0]   out_channel;
  logic            out_valid;
  logic            out_ready = 1'b0;
`ifdef RR_MUX_STATS_EN
  logic [15:0]     xfer_count;
`endif

  rr_mux_arbiter #(.N(N), .CHANNELS(CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .force_en    (force_en),
    .force_sel   (force_sel),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef RR_MUX_STATS_EN
    ,
    .xfer_count  (xfer_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [CH-1:0]   valid;
    logic [CH*N-1:0] data;
    logic            fe;
    logic [SW-1:0]   fs;
    logic            ordy;
    logic [CH-1:0]   exp_rdy;
    logic            exp_ov;
    logic [SW-1:0]   exp_ch;
    logic [N-1:0]    exp_d;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  initial begin
    //            valid  data fe    fs    ordy  rdy    ov    ch    data
    vecs[0]  = '{5'h1F, DB, 1'b0, 3'd0, 1'b1, 5'h01, 1'b1, 3'd0, 8'hD0};
    vecs[1]  = '{5'h1F, DB, 1'b0, 3'd0, 1'b1, 5'h02, 1'b1, 3'd1, 8'hD1};
    vecs[2]  = '{5'h1F, DB, 1'b0, 3'd0, 1'b1, 5'h04, 1'b1, 3'd2, 8'hD2};
    vecs[3]  = '{5'h1F, DB, 1'b0, 3'd0, 1'b1, 5'h08, 1'b1, 3'd3, 8'hD3};
    vecs[4]  = '{5'h1F, DB, 1'b0, 3'd0, 1'b1, 5'h10, 1'b1, 3'd4, 8'hD4};
    vecs[5]  = '{5'h1F, DB, 1'b0, 3'd0, 1'b1, 5'h01, 1'b1, 3'd0, 8'hD0};
    vecs[6]  = '{5'h1F, DB, 1'b0, 3'd0, 1'b1, 5'h02, 1'b1, 3'd1, 8'hD1};
    // load A5 from channel 2, then hold it for 3 cycles
    vecs[7]  = '{5'h1F, DA, 1'b0, 3'd0, 1'b1, 5'h04, 1'b1, 3'd2, 8'hA5};
    vecs[8]  = '{5'h1F, DB, 1'b0, 3'd0, 1'b0, 5'h00, 1'b1, 3'd2, 8'hA5};
    vecs[9]  = '{5'h1F, DB, 1'b0, 3'd0, 1'b0, 5'h00, 1'b1, 3'd2, 8'hA5};
    vecs[10] = '{5'h1F, DB, 1'b0, 3'd0, 1'b0, 5'h00, 1'b1, 3'd2, 8'hA5};
    vecs[11] = '{5'h1F, DB, 1'b0, 3'd0, 1'b1, 5'h08, 1'b1, 3'd3, 8'hD3};
    // rr_ptr=4, only channel 1 -> 1; ptr=2, channels 0,2 -> 2
    vecs[12] = '{5'h02, DB, 1'b0, 3'd0, 1'b1, 5'h02, 1'b1, 3'd1, 8'hD1};
    vecs[13] = '{5'h05, DB, 1'b0, 3'd0, 1'b1, 5'h04, 1'b1, 3'd2, 8'hD2};
    // forced channel 3 with 1 and 3 valid; then out-of-range select
    vecs[14] = '{5'h0A, DB, 1'b1, 3'd3, 1'b1, 5'h08, 1'b1, 3'd3, 8'hD3};
    vecs[15] = '{5'h0A, DB, 1'b1, 3'd3, 1'b1, 5'h08, 1'b1, 3'd3, 8'hD3};
    vecs[16] = '{5'h0A, DB, 1'b1, 3'd6, 1'b1, 5'h00, 1'b0, 3'd3, 8'hD3};
    vecs[17] = '{5'h0A, DB, 1'b1, 3'd6, 1'b1, 5'h00, 1'b0, 3'd3, 8'hD3};
    // forced load, then mode switch while held, then RR from ptr=2
    vecs[18] = '{5'h0A, DB, 1'b1, 3'd1, 1'b0, 5'h02, 1'b1, 3'd1, 8'hD1};
    vecs[19] = '{5'h0A, DB, 1'b0, 3'd1, 1'b0, 5'h00, 1'b1, 3'd1, 8'hD1};
    vecs[20] = '{5'h0A, DB, 1'b0, 3'd1, 1'b1, 5'h08, 1'b1, 3'd3, 8'hD3};
    vecs[21] = '{5'h00, DB, 1'b0, 3'd0, 1'b1, 5'h00, 1'b0, 3'd3, 8'hD3};
    vecs[22] = '{5'h00, DB, 1'b0, 3'd0, 1'b0, 5'h00, 1'b0, 3'd3, 8'hD3};
    // forced last channel, then RR wraps to 0
    vecs[23] = '{5'h1F, DB, 1'b1, 3'd4, 1'b1, 5'h10, 1'b1, 3'd4, 8'hD4};
    vecs[24] = '{5'h1F, DB, 1'b0, 3'd0, 1'b1, 5'h01, 1'b1, 3'd0, 8'hD0};

    // reset
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_channel", 64'(out_channel), 64'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      in_valid  = vecs[k].valid;
      in_data   = vecs[k].data;
      force_en  = vecs[k].fe;
      force_sel = vecs[k].fs;
      out_ready = vecs[k].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'(vecs[k].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(vecs[k].exp_ov));
      chk($sformatf("v%0d_out_channel", k), 64'(out_channel), 64'(vecs[k].exp_ch));
      chk($sformatf("v%0d_out_data", k), 64'(out_data), 64'(vecs[k].exp_d));
    end

    // asynchronous reset while a word is held (rr_ptr was 1)
    @(negedge clk);
    in_valid  = 5'h1F;
    in_data   = DB;
    force_en  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_before_reset_valid", 64'(out_valid), 64'd1);
    chk("hold_before_reset_channel", 64'(out_channel), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 64'(out_valid), 64'd0);
    chk("async_reset_out_data", 64'(out_data), 64'd0);
    chk("async_reset_out_channel", 64'(out_channel), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_reset_in_ready", 64'(in_ready), 64'h01);
    @(posedge clk);
    #1;
    chk("post_reset_out_valid", 64'(out_valid), 64'd1);
    chk("post_reset_out_channel", 64'(out_channel), 64'd0);
    chk("post_reset_out_data", 64'(out_data), 64'hD0);

`ifdef RR_MUX_STATS_EN
    chk("xfer_count_after_one", 64'(xfer_count), 64'd1);
    repeat (70000) @(posedge clk);
    #1;
    chk("xfer_count_saturated", 64'(xfer_count), 64'hFFFF);
    repeat (20) @(posedge clk);
    #1;
    chk("xfer_count_stays", 64'(xfer_count), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
